// File: rtl/mem_stage_pkg.sv
// Shared memory-op encodings for the execute/memory boundary and the
// legality rule for a memory access given its type and address offset.
package mem_stage_pkg;

   localparam int DWIDTH       = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int MEM_OP_LEN   = 2;
   localparam int MEM_TYPE_LEN = 3;

   localparam logic [MEM_OP_LEN-1:0] MEM_NONE  = 2'd0;
   localparam logic [MEM_OP_LEN-1:0] MEM_LOAD  = 2'd1;
   localparam logic [MEM_OP_LEN-1:0] MEM_STORE = 2'd2;

   localparam logic [MEM_TYPE_LEN-1:0] MEM_B  = 3'b000;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_H  = 3'b001;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_W  = 3'b010;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_BU = 3'b100;
   localparam logic [MEM_TYPE_LEN-1:0] MEM_HU = 3'b101;

   // Illegal type encodings (and unsigned stores) are reported as misaligned.
   function automatic logic mem_misaligned(input logic [MEM_OP_LEN-1:0]   op,
                                           input logic [MEM_TYPE_LEN-1:0] mtype,
                                           input logic [1:0]              off);
      logic bad;
      bad = 1'b1;
      case (mtype)
         MEM_B:  bad = 1'b0;
         MEM_H:  bad = off[0];
         MEM_W:  bad = (off != 2'b00);
         MEM_BU: bad = (op == MEM_STORE);
         MEM_HU: bad = (op == MEM_STORE) || off[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/half/word from a loaded memory word and
// sign- or zero-extends it according to the load type.
module lsu_load_align
   import mem_stage_pkg::*;
#(
   parameter int XLEN = DWIDTH
) (
   input  logic [XLEN-1:0]         rdata_i,
   input  logic [1:0]              off_i,
   input  logic [MEM_TYPE_LEN-1:0] type_i,
   output logic [XLEN-1:0]         data_o
);

   logic [XLEN-1:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      data_o = shifted;
      case (type_i)
         MEM_B:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         MEM_H:  data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         MEM_BU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         MEM_HU: data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU pass-through writeback or a single outstanding
// load/store on a req/gnt/rvalid data port, with one registered wb record.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN = DWIDTH,
   parameter int RA_W = REG_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ex_valid,
   output logic                    ex_ready,
   input  logic [MEM_OP_LEN-1:0]   ex_mem_op,
   input  logic [MEM_TYPE_LEN-1:0] ex_mem_type,
   input  logic [XLEN-1:0]         ex_alu_out,
   input  logic [XLEN-1:0]         ex_store_data,
   input  logic [RA_W-1:0]         ex_rd,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [3:0]              dmem_be,
   output logic [XLEN-1:0]         dmem_addr,
   output logic [XLEN-1:0]         dmem_wdata,
   input  logic                    dmem_gnt,
   input  logic                    dmem_rvalid,
   input  logic [XLEN-1:0]         dmem_rdata,
   output logic                    wb_valid,
   output logic                    wb_we,
   output logic [RA_W-1:0]         wb_rd,
   output logic [XLEN-1:0]         wb_data,
   output logic                    lsu_misaligned
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

   state_e                  state_q, state_d;
   logic                    store_q;
   logic [MEM_TYPE_LEN-1:0] type_q;
   logic [XLEN-1:0]         addr_q;
   logic [XLEN-1:0]         sdata_q;
   logic [RA_W-1:0]         rd_q;

   logic                    wb_valid_q, wb_valid_d;
   logic                    wb_we_q, wb_we_d;
   logic [RA_W-1:0]         wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]         wb_data_q, wb_data_d;
   logic                    misal_q, misal_d;

   logic                    accept;
   logic                    is_mem;
   logic                    in_req;
   logic [3:0]              be_c;
   logic [XLEN-1:0]         wdata_c;
   logic [XLEN-1:0]         load_data;

   assign ex_ready = (state_q == S_IDLE);
   assign accept   = ex_valid && ex_ready;
   assign is_mem   = (ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE);

   // Transaction operands are only meaningful while the FSM is busy, so
   // they carry no reset; every externally visible use is gated by state.
   always_ff @(posedge clk) begin
      if (accept) begin
         store_q <= (ex_mem_op == MEM_STORE);
         type_q  <= ex_mem_type;
         addr_q  <= ex_alu_out;
         sdata_q <= ex_store_data;
         rd_q    <= ex_rd;
      end
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = sdata_q;
      case (type_q)
         MEM_B, MEM_BU: begin
            be_c    = 4'b0001 << addr_q[1:0];
            wdata_c = {4{sdata_q[7:0]}};
         end
         MEM_H, MEM_HU: begin
            be_c    = 4'b0011 << addr_q[1:0];
            wdata_c = {2{sdata_q[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = sdata_q;
         end
      endcase
   end

   assign in_req     = (state_q == S_REQ);
   assign dmem_req   = in_req;
   assign dmem_we    = in_req && store_q;
   assign dmem_be    = in_req ? be_c : 4'b0000;
   assign dmem_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign dmem_wdata = in_req ? wdata_c : '0;

   lsu_load_align #(.XLEN(XLEN)) u_load_align (
      .rdata_i (dmem_rdata),
      .off_i   (addr_q[1:0]),
      .type_i  (type_q),
      .data_o  (load_data)
   );

   always_comb begin
      state_d    = state_q;
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_rd_d    = '0;
      wb_data_d  = '0;
      misal_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ex_valid) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = (ex_rd != '0);
                  wb_rd_d    = ex_rd;
                  wb_data_d  = ex_alu_out;
               end else if (mem_misaligned(ex_mem_op, ex_mem_type, ex_alu_out[1:0])) begin
                  misal_d = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (dmem_gnt) begin
               if (store_q) begin
                  state_d    = S_IDLE;
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (dmem_rvalid) begin
               state_d    = S_IDLE;
               wb_valid_d = 1'b1;
               wb_we_d    = (rd_q != '0);
               wb_rd_d    = rd_q;
               wb_data_d  = load_data;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         misal_q    <= misal_d;
      end
   end

   assign wb_valid       = wb_valid_q;
   assign wb_we          = wb_we_q;
   assign wb_rd          = wb_rd_q;
   assign wb_data        = wb_data_q;
   assign lsu_misaligned = misal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table of memory ops with a writeback
// scoreboard, plus hand sequences for pass-through, spurious rvalid and reset.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [1:0]  ex_mem_op = '0;
   logic [2:0]  ex_mem_type = '0;
   logic [31:0] ex_alu_out = '0;
   logic [31:0] ex_store_data = '0;
   logic [4:0]  ex_rd = '0;
   logic        dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        lsu_misaligned;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
      .ex_mem_type(ex_mem_type), .ex_alu_out(ex_alu_out),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .lsu_misaligned(lsu_misaligned)
   );

   typedef struct {
      logic        misal;
      logic        we;
      logic        chk_data;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [2:0]  mtype;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          gnt_wait;
      logic        misal;
      logic [31:0] daddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] wb_data;
      logic        wb_we;
   } vec_t;

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   // Scoreboard: every wb or misaligned pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && (wb_valid || lsu_misaligned)) begin
         if (sbq.size() == 0) begin
            check1("sb_unexpected_output", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check1("sb_misal", lsu_misaligned, e.misal);
            check1("sb_wb_valid", wb_valid, !e.misal);
            if (!e.misal) check1("sb_wb_we", wb_we, e.we);
            if (!e.misal && e.chk_data) begin
               check32("sb_wb_data", wb_data, e.data);
               check32("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            end
         end
      end
   end

   function automatic vec_t mk(input string nm, input logic [1:0] op, input logic [2:0] mt,
                               input logic [31:0] addr, input logic [31:0] sd,
                               input logic [31:0] rdat, input logic [4:0] rd, input int gw,
                               input logic mis, input logic [31:0] da, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] wbd, input logic wbwe);
      vec_t v;
      v.name = nm; v.op = op; v.mtype = mt; v.addr = addr; v.sdata = sd; v.rdata = rdat;
      v.rd = rd; v.gnt_wait = gw; v.misal = mis; v.daddr = da; v.be = be; v.wdata = wd;
      v.wb_data = wbd; v.wb_we = wbwe;
      return v;
   endfunction

   task automatic push_exp(input logic mis, input logic we, input logic cd,
                           input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.misal = mis; e.we = we; e.chk_data = cd; e.rd = rd; e.data = d;
      sbq.push_back(e);
   endtask

   task automatic run_vec(input vec_t v);
      logic is_st;
      is_st = (v.op == MEM_STORE);
      @(posedge clk); #1;
      check1({v.name, ".ready"}, ex_ready, 1'b1);
      ex_valid = 1'b1; ex_mem_op = v.op; ex_mem_type = v.mtype;
      ex_alu_out = v.addr; ex_store_data = v.sdata; ex_rd = v.rd;
      push_exp(v.misal, v.wb_we, !is_st, v.rd, v.wb_data);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      if (v.misal) begin
         check1({v.name, ".no_req"}, dmem_req, 1'b0);
         check1({v.name, ".misal"}, lsu_misaligned, 1'b1);
         check1({v.name, ".no_wb"}, wb_valid, 1'b0);
         @(posedge clk); #1;
         check1({v.name, ".no_req2"}, dmem_req, 1'b0);
         check1({v.name, ".misal_pulse"}, lsu_misaligned, 1'b0);
      end else begin
         for (int w = 0; w <= v.gnt_wait; w++) begin
            check1({v.name, ".req"}, dmem_req, 1'b1);
            check1({v.name, ".ready_low"}, ex_ready, 1'b0);
            check1({v.name, ".we"}, dmem_we, is_st);
            check32({v.name, ".addr"}, dmem_addr, v.daddr);
            check32({v.name, ".be"}, {28'd0, dmem_be}, {28'd0, v.be});
            if (is_st) check32({v.name, ".wdata"}, dmem_wdata, v.wdata);
            dmem_gnt = (w == v.gnt_wait);
            @(posedge clk); #1;
         end
         dmem_gnt = 1'b0;
         if (!is_st) begin
            check1({v.name, ".wait_no_req"}, dmem_req, 1'b0);
            check1({v.name, ".wait_no_wb"}, wb_valid, 1'b0);
            dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0; dmem_rdata = '0;
         end
         check1({v.name, ".wb_now"}, wb_valid, 1'b1);
      end
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = mk("sb_1003",  MEM_STORE, MEM_B,  32'h1003, 32'hAABBCCDD, 32'h0, 5'd3, 2, 1'b0, 32'h1000, 4'b1000, 32'hDDDDDDDD, 32'h0, 1'b0);
      vecs[1]  = mk("lb_2002",  MEM_LOAD,  MEM_B,  32'h2002, 32'h0, 32'h00800000, 5'd7, 0, 1'b0, 32'h2000, 4'b0100, 32'h0, 32'hFFFFFF80, 1'b1);
      vecs[2]  = mk("lbu_2002", MEM_LOAD,  MEM_BU, 32'h2002, 32'h0, 32'h00800000, 5'd7, 1, 1'b0, 32'h2000, 4'b0100, 32'h0, 32'h00000080, 1'b1);
      vecs[3]  = mk("lh_2002",  MEM_LOAD,  MEM_H,  32'h2002, 32'h0, 32'h80010000, 5'd8, 0, 1'b0, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 1'b1);
      vecs[4]  = mk("lw_3001",  MEM_LOAD,  MEM_W,  32'h3001, 32'h0, 32'h0, 5'd9, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
      vecs[5]  = mk("sh_3003",  MEM_STORE, MEM_H,  32'h3003, 32'h11112222, 32'h0, 5'd0, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
      vecs[6]  = mk("lw_4004",  MEM_LOAD,  MEM_W,  32'h4004, 32'h0, 32'hDEADBEEF, 5'd9, 0, 1'b0, 32'h4004, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b1);
      vecs[7]  = mk("sh_1002",  MEM_STORE, MEM_H,  32'h1002, 32'h12345678, 32'h0, 5'd0, 1, 1'b0, 32'h1000, 4'b1100, 32'h56785678, 32'h0, 1'b0);
      vecs[8]  = mk("sw_1008",  MEM_STORE, MEM_W,  32'h1008, 32'hCAFEF00D, 32'h0, 5'd4, 1, 1'b0, 32'h1008, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
      vecs[9]  = mk("lhu_2000", MEM_LOAD,  MEM_HU, 32'h2000, 32'h0, 32'h1234F00D, 5'd10, 0, 1'b0, 32'h2000, 4'b0011, 32'h0, 32'h0000F00D, 1'b1);
      vecs[10] = mk("lb_rd0",   MEM_LOAD,  MEM_B,  32'h2001, 32'h0, 32'h0000AB00, 5'd0, 0, 1'b0, 32'h2000, 4'b0010, 32'h0, 32'hFFFFFFAB, 1'b0);
      vecs[11] = mk("sbu_ill",  MEM_STORE, MEM_BU, 32'h1000, 32'h55, 32'h0, 5'd1, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
      vecs[12] = mk("l011_ill", MEM_LOAD,  3'b011, 32'h1000, 32'h0, 32'h0, 5'd1, 0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check1("rst.ready", ex_ready, 1'b1);
      check1("rst.req", dmem_req, 1'b0);
      check32("rst.addr", dmem_addr, 32'h0);
      check1("rst.wb_valid", wb_valid, 1'b0);
      check32("rst.wb_data", wb_data, 32'h0);
      check1("rst.misal", lsu_misaligned, 1'b0);
      rst_n = 1'b1;

      // ALU pass-through, three back-to-back accepts
      for (int i = 0; i <= 3; i++) begin
         @(posedge clk); #1;
         if (i > 0) check1("alu.wb_pulse", wb_valid, 1'b1);
         if (i < 3) begin
            check1("alu.ready", ex_ready, 1'b1);
            ex_valid = 1'b1; ex_mem_op = MEM_NONE; ex_mem_type = MEM_W;
            ex_alu_out = 32'h1234; ex_rd = 5'd5;
            push_exp(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234);
         end else begin
            ex_valid = 1'b0;
         end
      end

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // Spurious rvalid while idle
      @(posedge clk); #1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF0000;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0; dmem_rdata = '0;
      check1("spur.no_wb", wb_valid, 1'b0);
      check1("spur.ready", ex_ready, 1'b1);

      // Reset while a load waits for rvalid
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_mem_op = MEM_LOAD; ex_mem_type = MEM_W;
      ex_alu_out = 32'h5000; ex_rd = 5'd6;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      check1("rstld.req", dmem_req, 1'b1);
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      check1("rstld.wait_ready", ex_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check1("rstld.ready", ex_ready, 1'b1);
      check1("rstld.req", dmem_req, 1'b0);
      check1("rstld.wb", wb_valid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check1("post.ready", ex_ready, 1'b1);
      ex_valid = 1'b1; ex_mem_op = MEM_NONE; ex_alu_out = 32'hBEEF; ex_rd = 5'd2;
      push_exp(1'b0, 1'b1, 1'b1, 5'd2, 32'hBEEF);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      check1("post.wb", wb_valid, 1'b1);
      @(posedge clk); #1;
      check32("sb_empty", 32'(sbq.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage directly downstream of the execute-stage ALU.
- Takes the registered ALU result, used either as a pass-through writeback value or as a load/store effective address.
- Drives a req/gnt/rvalid data-memory port with byte-lane alignment, store-data replication and load sign/zero extension.
- Presents one registered writeback record per accepted instruction, and stalls execute while a memory transaction is outstanding.

Parameters:
- XLEN, `DWIDTH (32): datapath width; only 32 is supported.
- RA_W, 5: register-index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept; equals (state==IDLE)
- ex_mem_op  in  2  `MEM_NONE / `MEM_LOAD / `MEM_STORE
- ex_mem_type  in  3  funct3 encoding: B=000, H=001, W=010, BU=100, HU=101
- ex_alu_out  in  XLEN  ALU result or effective address
- ex_store_data  in  XLEN  rs2 value
- ex_rd  in  RA_W  destination register
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables
- dmem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data word
- wb_valid  out  1  writeback record valid; 1-cycle pulse
- wb_we  out  1  register-file write enable
- wb_rd  out  RA_W  destination register
- wb_data  out  XLEN  writeback value
- lsu_misaligned  out  1  1-cycle exception pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 except ex_ready=1.
  - Any in-flight transaction is abandoned.
  - The memory shares rst_n, so no stale rvalid can follow a reset.
- FSM states: IDLE, REQ, WAIT.
- Accept = ex_valid && ex_ready. Accepting captures op, type, alu_out, store_data and rd.
- IDLE, accept of MEM_NONE:
  - Next cycle: wb_valid=1, wb_data=alu_out, wb_rd=rd, wb_we=(rd!=0).
  - Back-to-back accepts sustain 1 instruction/cycle.
- IDLE, accept of a memory op:
  - Alignment is checked on alu_out: H/HU/SH need addr[0]=0; W needs addr[1:0]=0.
  - An illegal ex_mem_type (011, 110, 111, or BU/HU on a store) counts as misaligned.
  - Misaligned: next cycle lsu_misaligned=1 and wb_valid=0; no dmem_req is issued; stay in IDLE.
  - Aligned: go to REQ.
- REQ:
  - dmem_req=1 with addr, we, be and wdata held stable until dmem_gnt.
  - On gnt with a store: go to IDLE; next cycle wb_valid=1, wb_we=0.
  - On gnt with a load: go to WAIT.
- WAIT:
  - dmem_req=0.
  - On dmem_rvalid: the load-aligned value is registered; next cycle wb_valid=1, wb_we=(rd!=0), and the FSM returns to IDLE.
- dmem_rvalid outside WAIT is ignored. rvalid in the same cycle as gnt is not honoured; the memory guarantees rvalid no earlier than the cycle after gnt.
- Byte enables: B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111.
- Store data replication: B: {4{sd[7:0]}}; H: {2{sd[15:0]}}; W: sd.
- Load alignment: the selected byte/half is taken from rdata >> (8*addr[1:0]). B/H are sign-extended; BU/HU are zero-extended; W is passed as is.
- Latency:
  - ALU op: wb one cycle after accept.
  - Store: wb at gnt+1.
  - Load: wb at rvalid+1.
  - Minimum load (gnt on the first REQ cycle, rvalid the cycle after): accept at T, req/gnt at T+1, rvalid at T+2, wb at T+3.
- Ordering: one outstanding memory transaction, so writebacks occur in program order.
- ex_ready is deasserted in REQ and WAIT; upstream holds its inputs.

Decomposition:
- Shared package (control_signals.v / consts.v):
  - `MEM_NONE, `MEM_LOAD, `MEM_STORE
  - `MEM_B, `MEM_H, `MEM_W, `MEM_BU, `MEM_HU
  - `MEM_OP_LEN, `MEM_TYPE_LEN
- State encodings stay local to the module.
- Sub-module lsu_load_align: combinational extraction and sign/zero extension from (rdata, addr[1:0], type). It is reusable and testable in isolation.

Test Plan:
- ALU pass-through: accept MEM_NONE, alu_out=0x1234, rd=5 on 3 consecutive cycles -> 3 consecutive wb_valid pulses with wb_data=0x1234, wb_we=1, ex_ready never drops.
- Store byte: SB addr=0x1003, sd=0xAABBCCDD, gnt after 2 wait cycles -> dmem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, all held stable 3 cycles; then wb_valid=1, wb_we=0.
- Load sign/zero extension: LB addr=0x2002 with rdata=0x00800000 -> wb_data=0xFFFFFF80; repeat with LBU -> wb_data=0x00000080; LH addr=0x2002, rdata=0x80010000 -> wb_data=0xFFFF8001.
- Misaligned: LW addr=0x3001 -> lsu_misaligned pulse, no dmem_req, no wb_valid; SH addr=0x3003 -> same.
- rd=0 and spurious rvalid: load to rd=0 -> wb_valid=1, wb_we=0; rvalid pulsed while in IDLE -> no wb_valid.
- Reset mid-load: assert rst_n=0 while in WAIT -> outputs cleared immediately, ex_ready=1 after release; the next MEM_NONE accept completes normally.
